// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between an SPI slave byte interface and an internal register bus.
// Optional frame timeout is compiled in when SPI_CMD_TIMEOUT_EN is defined.
module spi_cmd_ctrl #(
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter int         TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              byte_first,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_ack,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_W, WAIT_R} state_t;

  state_t            state, state_nxt;
  logic              vld_p0, first_p0;
  logic [7:0]        data_p0;
  logic              evt_cmd, evt_data, evt_late;
  logic              hold_vld, hold_nxt;
  logic [7:0]        hold_byte, hold_byte_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        wdata_nxt, tx_nxt;
  logic              wr_nxt, rd_nxt, ovr_nxt;
  logic              tmo_hit;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // Stage p0: hold the received byte one clk so a late first-byte flag can still classify it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
    end else if (byte_valid) begin
      vld_p0   <= 1'b1;
      first_p0 <= byte_first;
    end else if (evt_late) begin
      first_p0 <= 1'b1;
    end else begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) data_p0 <= byte_data;
  end

  assign evt_cmd  = vld_p0 & first_p0;
  assign evt_late = vld_p0 & ~first_p0 & byte_first;
  assign evt_data = vld_p0 & ~first_p0 & ~byte_first;

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (byte_valid || state == IDLE) begin
      tmo_cnt <= '0;
    end else if ((state == WRITE || state == READ) && tmo_cnt != TMO_W'(TIMEOUT)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state == WRITE || state == READ) && (tmo_cnt == TMO_W'(TIMEOUT));
`else
  // Frames never expire in this build; the comparison is constant false.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_nxt     = state;
    addr_nxt      = reg_addr;
    wdata_nxt     = reg_wdata;
    wr_nxt        = reg_wr;
    rd_nxt        = reg_rd;
    tx_nxt        = tx_data;
    ovr_nxt       = overrun;
    hold_nxt      = hold_vld;
    hold_byte_nxt = hold_byte;

    if (evt_cmd) begin
      hold_nxt      = 1'b1;
      hold_byte_nxt = data_p0;
    end

    if (reg_wr || reg_rd) begin
      if (evt_data) ovr_nxt = 1'b1;
      if (reg_ack) begin
        wr_nxt = 1'b0;
        rd_nxt = 1'b0;
        if (hold_nxt) begin
          // Abandoned access finished: drop its result and start the new command at once
          hold_nxt = 1'b0;
          ovr_nxt  = 1'b0;
          addr_nxt = hold_byte_nxt[ADDR_W-1:0];
          if (hold_byte_nxt[7]) begin
            state_nxt = WRITE;
          end else begin
            rd_nxt    = 1'b1;
            state_nxt = WAIT_R;
          end
        end else if (state == WAIT_W) begin
          addr_nxt  = addr_inc(reg_addr);
          state_nxt = WRITE;
        end else begin
          tx_nxt    = reg_rdata;
          state_nxt = READ;
        end
      end
    end else if (hold_nxt) begin
      hold_nxt = 1'b0;
      ovr_nxt  = 1'b0;
      addr_nxt = hold_byte_nxt[ADDR_W-1:0];
      if (hold_byte_nxt[7]) begin
        state_nxt = WRITE;
      end else begin
        rd_nxt    = 1'b1;
        state_nxt = WAIT_R;
      end
    end else if (tmo_hit) begin
      state_nxt = IDLE;
      tx_nxt    = IDLE_BYTE;
    end else if (evt_data) begin
      case (state)
        WRITE: begin
          wdata_nxt = data_p0;
          wr_nxt    = 1'b1;
          state_nxt = WAIT_W;
        end
        READ: begin
          addr_nxt  = addr_inc(reg_addr);
          rd_nxt    = 1'b1;
          state_nxt = WAIT_R;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: sequencer state and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      tx_data   <= IDLE_BYTE;
      overrun   <= 1'b0;
      hold_vld  <= 1'b0;
    end else begin
      state     <= state_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      reg_wr    <= wr_nxt;
      reg_rd    <= rd_nxt;
      tx_data   <= tx_nxt;
      overrun   <= ovr_nxt;
      hold_vld  <= hold_nxt;
    end
  end

  always_ff @(posedge clk) begin
    hold_byte <= hold_byte_nxt;
  end

  assign busy = reg_wr | reg_rd;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed vector table, corner sequences and
// randomized frames checked against a frame-level register model.
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_first = 1'b0;
  logic [7:0] tx_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr, reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_ack = 1'b0;
  logic       overrun, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int ack_dly = 2;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] val;
  } txn_t;

  txn_t got_q[$];
  txn_t exp_q[$];
  logic [7:0] mem    [128];
  logic [7:0] shadow [128];

  spi_cmd_ctrl #(.ADDR_W(7), .IDLE_BYTE(8'h00), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_first(byte_first), .tx_data(tx_data), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Register bus slave plus protocol monitor, all on the falling edge
  int   age = 0;
  logic req_prev = 1'b0, wr_prev = 1'b0;
  logic [6:0] addr_prev = '0;
  logic [7:0] wdata_prev = '0;
  always @(negedge clk) begin
    if (rst) begin
      reg_ack  = 1'b0;
      age      = 0;
      req_prev = 1'b0;
    end else begin
      check("mon_excl", 32'(reg_wr & reg_rd), 32'd0);
      check("mon_busy", 32'(busy), 32'(reg_wr | reg_rd));
      if (req_prev && !reg_ack) begin
        check("mon_hold_type", 32'({reg_wr, reg_rd}), 32'({wr_prev, ~wr_prev}));
        check("mon_hold_addr", 32'(reg_addr), 32'(addr_prev));
        if (wr_prev) check("mon_hold_wdata", 32'(reg_wdata), 32'(wdata_prev));
      end
      req_prev   = reg_wr | reg_rd;
      wr_prev    = reg_wr;
      addr_prev  = reg_addr;
      wdata_prev = reg_wdata;
      if (reg_ack) begin
        reg_ack = 1'b0;
        age     = 0;
      end else if (reg_wr || reg_rd) begin
        age++;
        if (age >= ack_dly) begin
          reg_ack = 1'b1;
          if (reg_wr) begin
            mem[reg_addr] = reg_wdata;
            got_q.push_back('{wr: 1'b1, addr: reg_addr, val: reg_wdata});
          end else begin
            reg_rdata = mem[reg_addr];
            got_q.push_back('{wr: 1'b0, addr: reg_addr, val: mem[reg_addr]});
          end
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit is_cmd, input bit late, input int gap);
    @(negedge clk);
    byte_data  = d;
    byte_valid = 1'b1;
    byte_first = is_cmd && !late;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_first = is_cmd && late;
    @(negedge clk);
    byte_first = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic compare_log(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({name, "_txn"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!(reg_wr || reg_rd) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_req", 32'(reg_wr | reg_rd), 32'd1);
  endtask

  typedef struct packed {
    logic [7:0]      cmd;
    logic            late;
    logic [2:0]      nd;
    logic [2:0][7:0] d;
    logic [2:0]      nexp;
    logic [3:0]      exp_wr;
    logic [3:0][6:0] exp_addr;
    logic [3:0][7:0] exp_val;
  } vec_t;

  vec_t vec[5];

  initial begin
    logic [7:0] tx_before, cmd, d;
    logic [6:0] a;
    int nd;
    bit late;

    vec[0] = '{cmd: 8'h85, late: 1'b0, nd: 3'd3, d: {8'h33, 8'h22, 8'h11}, nexp: 3'd3,
               exp_wr: 4'b0111, exp_addr: {7'h00, 7'h07, 7'h06, 7'h05},
               exp_val: {8'h00, 8'h33, 8'h22, 8'h11}};
    vec[1] = '{cmd: 8'h10, late: 1'b0, nd: 3'd3, d: {8'h00, 8'h00, 8'h00}, nexp: 3'd4,
               exp_wr: 4'b0000, exp_addr: {7'h13, 7'h12, 7'h11, 7'h10},
               exp_val: {8'h01, 8'hEF, 8'hCD, 8'hAB}};
    vec[2] = '{cmd: 8'hFF, late: 1'b0, nd: 3'd2, d: {8'h00, 8'hB2, 8'hA1}, nexp: 3'd2,
               exp_wr: 4'b0011, exp_addr: {7'h00, 7'h00, 7'h00, 7'h7F},
               exp_val: {8'h00, 8'h00, 8'hB2, 8'hA1}};
    vec[3] = '{cmd: 8'h02, late: 1'b1, nd: 3'd0, d: {8'h00, 8'h00, 8'h00}, nexp: 3'd1,
               exp_wr: 4'b0000, exp_addr: {7'h00, 7'h00, 7'h00, 7'h02},
               exp_val: {8'h00, 8'h00, 8'h00, 8'h5C}};
    vec[4] = '{cmd: 8'h83, late: 1'b0, nd: 3'd1, d: {8'h00, 8'h00, 8'h44}, nexp: 3'd1,
               exp_wr: 4'b0001, exp_addr: {7'h00, 7'h00, 7'h00, 7'h03},
               exp_val: {8'h00, 8'h00, 8'h00, 8'h44}};

    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3 + 1);
    mem[8'h10] = 8'hAB; mem[8'h11] = 8'hCD; mem[8'h12] = 8'hEF; mem[8'h13] = 8'h01;
    mem[8'h02] = 8'h5C;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_data), 32'h00);
    check("rst_wr", 32'(reg_wr), 32'd0);
    check("rst_rd", 32'(reg_rd), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      send_byte(vec[v].cmd, 1'b1, vec[v].late, 10);
      if (!vec[v].cmd[7]) check("vec_tx_cmd", 32'(tx_data), 32'(vec[v].exp_val[0]));
      for (int j = 0; j < int'(vec[v].nd); j++) begin
        send_byte(vec[v].d[j], 1'b0, 1'b0, 10);
        if (!vec[v].cmd[7]) check("vec_tx_data", 32'(tx_data), 32'(vec[v].exp_val[j+1]));
      end
      for (int k = 0; k < int'(vec[v].nexp); k++)
        exp_q.push_back('{wr: vec[v].exp_wr[k], addr: vec[v].exp_addr[k], val: vec[v].exp_val[k]});
      compare_log("vec_log");
      check("vec_overrun", 32'(overrun), 32'd0);
    end

    // Overrun: second data byte lands while the first write is still waiting for ack
    ack_dly = 8;
    send_byte(8'h80, 1'b1, 1'b0, 4);
    send_byte(8'h99, 1'b0, 1'b0, 0);
    send_byte(8'h55, 1'b0, 1'b0, 0);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_wdata_hold", 32'(reg_wdata), 32'h99);
    repeat (12) @(negedge clk);
    exp_q.push_back('{wr: 1'b1, addr: 7'h00, val: 8'h99});
    compare_log("ovr_log");
    check("ovr_addr", 32'(reg_addr), 32'h01);
    check("ovr_sticky", 32'(overrun), 32'd1);
    send_byte(8'h81, 1'b1, 1'b0, 4);
    check("ovr_clear", 32'(overrun), 32'd0);
    check("ovr_cmd_addr", 32'(reg_addr), 32'h01);

    // Late first flag on a read command, then a write command aborts the pending read
    ack_dly = 6;
    mem[8'h02] = 8'hE7;
    tx_before = tx_data;
    send_byte(8'h02, 1'b1, 1'b1, 2);
    check("late_rd", 32'(reg_rd), 32'd1);
    check("late_addr", 32'(reg_addr), 32'h02);
    send_byte(8'h83, 1'b1, 1'b0, 6);
    check("abort_addr", 32'(reg_addr), 32'h03);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_tx_kept", 32'(tx_data), 32'(tx_before));
    send_byte(8'h77, 1'b0, 1'b0, 10);
    exp_q.push_back('{wr: 1'b0, addr: 7'h02, val: 8'hE7});
    exp_q.push_back('{wr: 1'b1, addr: 7'h03, val: 8'h77});
    compare_log("abort_log");
    check("abort_next_addr", 32'(reg_addr), 32'h04);

    // Asynchronous reset while a read is outstanding
    ack_dly = 10;
    check("pre_rst_tx", 32'(tx_data != 8'h00), 32'd1);
    send_byte(8'h10, 1'b1, 1'b0, 0);
    wait_req(6);
    #2 rst = 1'b1;
    #1;
    check("arst_rd", 32'(reg_rd), 32'd0);
    check("arst_tx", 32'(tx_data), 32'h00);
    check("arst_addr", 32'(reg_addr), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    compare_log("arst_log");
    ack_dly = 2;

`ifdef SPI_CMD_TIMEOUT_EN
    send_byte(8'h10, 1'b1, 1'b0, 10);
    check("tmo_pre_tx", 32'(tx_data), 32'hAB);
    send_byte(8'h80, 1'b1, 1'b0, 20);
    check("tmo_tx_idle", 32'(tx_data), 32'h00);
    send_byte(8'h66, 1'b0, 1'b0, 10);
    exp_q.push_back('{wr: 1'b0, addr: 7'h10, val: 8'hAB});
    compare_log("tmo_log");
`else
    send_byte(8'h80, 1'b1, 1'b0, 40);
    send_byte(8'h66, 1'b0, 1'b0, 10);
    exp_q.push_back('{wr: 1'b1, addr: 7'h00, val: 8'h66});
    compare_log("persist_log");
`endif

    // Random frames against a frame-level register model
    for (int i = 0; i < 128; i++) begin
      mem[i]    = 8'($urandom);
      shadow[i] = mem[i];
    end
    for (int f = 0; f < 30; f++) begin
      cmd     = 8'($urandom);
      nd      = $urandom_range(0, 4);
      late    = 1'($urandom_range(0, 1));
      ack_dly = $urandom_range(1, 3);
      a       = cmd[6:0];
      send_byte(cmd, 1'b1, late, 10);
      if (!cmd[7]) exp_q.push_back('{wr: 1'b0, addr: a, val: shadow[a]});
      for (int j = 1; j <= nd; j++) begin
        d = 8'($urandom);
        if (cmd[7]) begin
          exp_q.push_back('{wr: 1'b1, addr: 7'(a + j - 1), val: d});
          shadow[7'(a + j - 1)] = d;
        end else begin
          check("rnd_tx", 32'(tx_data), 32'(shadow[7'(a + j - 1)]));
          exp_q.push_back('{wr: 1'b0, addr: 7'(a + j), val: shadow[7'(a + j)]});
        end
        send_byte(d, 1'b0, 1'b0, 10);
      end
      if (!cmd[7]) check("rnd_tx_last", 32'(tx_data), 32'(shadow[7'(a + nd)]));
      compare_log("rnd_log");
      check("rnd_overrun", 32'(overrun), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer between the SPI slave byte interface and the internal register bus.
- Decodes the first byte of each CS frame as a command: read/write flag plus 7-bit start address.
- Performs auto-incrementing register writes or prefetched register reads.
- Drives the slave's transmit byte (sdata) so read data is shifted out one byte after it is fetched.

Parameters:
ADDR_W, 7, register address width; the command byte carries ADDR_W address bits in bits [ADDR_W-1:0]
IDLE_BYTE, 8'h00, value driven on sdata after reset and while no read is active
TIMEOUT, 4096, clk cycles without a byte before the frame is abandoned (optional feature only)

Ports:
clk  in  1  system clock; sole clock of the block
rst  in  1  asynchronous reset, active high
byte_data  in  8  received byte (slave mdata); stable when byte_valid pulses
byte_valid  in  1  one-clk pulse per received byte (slave data_valid_read)
byte_first  in  1  one-clk pulse marking the first byte of a frame (slave data_firstbyte); same cycle as byte_valid or up to 1 clk later
tx_data  out  8  next byte to transmit (to slave sdata)
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  register write data
reg_wr  out  1  write request; held until reg_ack
reg_rd  out  1  read request; held until reg_ack
reg_rdata  in  8  read data; valid in the reg_ack cycle
reg_ack  in  1  one-clk access completion
overrun  out  1  sticky: a byte arrived while an access was still pending
busy  out  1  high whenever reg_wr or reg_rd is high

Behaviour:
- Reset (async) values: tx_data=IDLE_BYTE; reg_wr=reg_rd=0; reg_addr=0; reg_wdata=0; overrun=0; state=IDLE.
- Byte qualification:
  - A byte_valid is latched as pending for 1 clk.
  - If byte_first arrives in the same cycle or the next cycle, the byte is a command byte; otherwise it is a data byte.
  - Byte processing therefore occurs 1 clk after byte_valid, or 2 clk if byte_first is late.
- States: IDLE, WRITE, READ, WAIT_W, WAIT_R.
- Command byte, from any state (abandons the current frame):
  - reg_addr = byte_data[ADDR_W-1:0]; overrun cleared.
  - byte_data[7]=1: go to WRITE.
  - byte_data[7]=0: assert reg_rd at the new address and go to WAIT_R.
  - If an access is pending when the command byte arrives, that access is allowed to finish first: its ack is consumed and its data discarded. The new command's access is issued the cycle after the ack.
- WRITE: a data byte sets reg_wdata=byte_data, asserts reg_wr, and goes to WAIT_W.
- WAIT_W:
  - On reg_ack: drop reg_wr; reg_addr increments, wrapping from 2^ADDR_W-1 to 0; return to WRITE.
- WAIT_R:
  - On reg_ack: tx_data=reg_rdata; drop reg_rd; go to READ.
- READ: a data byte (dummy/clocking byte) increments reg_addr (with wrap), asserts reg_rd, and goes to WAIT_R.
- Resulting read protocol on the wire:
  - byte 0 = command; byte 1 returns the previous tx_data (don't-care); byte 2 returns reg[A]; byte 3 returns reg[A+1]; and so on.
  - Register latency must be shorter than one SPI byte time; the block does not check this.
- Overrun:
  - A data byte arriving in WAIT_W or WAIT_R sets overrun=1 and the byte is dropped.
  - No address increment and no new request result.
  - The pending access completes normally.
- reg_wr and reg_rd are never high together.
- reg_addr and reg_wdata are stable while a request is high.
- byte_first without a byte_valid in the preceding cycle is ignored.
- No CS input: a frame ends only when the next command byte arrives (or on timeout, if enabled).
- Async rst mid-access drops requests immediately. The bus owner must tolerate this abort.

Optional Feature:
- Macro: SPI_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) resets on every byte_valid and counts in WRITE/READ.
  - On reaching TIMEOUT: return to IDLE; tx_data=IDLE_BYTE. Subsequent data bytes are ignored until the next command byte.
  - Counting is frozen in the WAIT_* states.
- Undefined: no counter; WRITE/READ persist indefinitely; the TIMEOUT parameter is unused.

Test Plan:
- Write burst:
  - Stimulus: cmd 8'h85, data 8'h11, 8'h22, 8'h33; ack 2 clk after each request.
  - Response: writes to addr 5/6/7 with data 11/22/33; overrun=0.
- Read burst:
  - Setup: regs 0x10=8'hAB, 0x11=8'hCD; cmd 8'h10 then 3 dummy bytes.
  - Response: tx_data=AB after first ack, CD after second; reg_rd issued at 0x10, 0x11, 0x12.
- Wrap: cmd 8'hFF, 2 data bytes -> writes at addr 7F then 00.
- Overrun:
  - Stimulus: cmd 8'h80, data byte, second data byte before ack.
  - Response: overrun=1; only one write (addr 0); the next cmd clears overrun.
- Late first flag and abort:
  - Stimulus: byte_first 1 clk after byte_valid on 8'h02; then a new cmd 8'h83 while a reg_rd is pending.
  - Response: first byte decoded as a read of addr 2; the pending read completes and is discarded; state goes to WRITE at addr 3.
- Reset and timeout:
  - rst asserted mid-WAIT_R: reg_rd drops in the same cycle and tx_data=00.
  - With SPI_CMD_TIMEOUT_EN and TIMEOUT=16: 17 idle clk in WRITE, then a data byte -> no write issued.
